// File: rtl/sdram_cmd_frontend_pkg.sv
// Shared types for the SDRAM command front end: controller command payload.
package sdram_cmd_frontend_pkg;

  localparam int unsigned CMD_ADDR_WIDTH = 24;

  typedef enum logic {
    READ_CMD  = 1'b0,
    WRITE_CMD = 1'b1
  } sdram_rw_e;

  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0] addr;
    sdram_rw_e                 rw;
    logic                      auto_precharge_en;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_cmd_frontend_if.sv
// User-side and controller-side handshake bundle of the SDRAM command front end.
interface sdram_cmd_frontend_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  import sdram_cmd_frontend_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [CMD_ADDR_WIDTH-1:0] req_addr;
  logic                      req_ap;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [1:0]                wr_dqm;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      cmd_valid;
  logic                      cmd_ready;
  sdram_cmd_t                cmd_data;
  logic                      wdata_valid;
  logic                      wdata_ready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [1:0]                wdata_dqm;
  logic                      resp_valid;
  logic                      resp_last;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic                      resp_ready;
  logic                      err_o;

  // master: user and controller side (drives requests, data and responses)
  modport master (
    output req_valid, req_write, req_addr, req_ap, wr_valid, wr_data, wr_dqm,
           rd_ready, cmd_ready, wdata_ready, resp_valid, resp_last, resp_data,
    input  req_ready, wr_ready, rd_valid, rd_data, cmd_valid, cmd_data,
           wdata_valid, wdata, wdata_dqm, resp_ready, err_o
  );

  // slave: the front end itself
  modport slave (
    input  req_valid, req_write, req_addr, req_ap, wr_valid, wr_data, wr_dqm,
           rd_ready, cmd_ready, wdata_ready, resp_valid, resp_last, resp_data,
    output req_ready, wr_ready, rd_valid, rd_data, cmd_valid, cmd_data,
           wdata_valid, wdata, wdata_dqm, resp_ready, err_o
  );

endinterface

// File: rtl/sdram_cmd_frontend.sv
// Burst-granular front end ahead of the SDRAM controller: buffers commands,
// write data and read data, and releases a command only when its burst cannot stall.
module sdram_cmd_frontend_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

module sdram_cmd_frontend
  import sdram_cmd_frontend_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CMD_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned WDATA_DEPTH = 32,
  parameter int unsigned RDATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  sdram_cmd_frontend_if.slave   bus
);
  localparam int unsigned CCW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned WCW = $clog2(WDATA_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RDATA_DEPTH) + 1;

  sdram_cmd_t       req_cmd;
  sdram_cmd_t       head;
  logic [CCW-1:0]   cmd_count;
  logic [WCW-1:0]   wd_count;
  logic [RCW-1:0]   rd_count;
  logic [WCW-1:0]   wclaim;
  logic [WCW-1:0]   wavail;
  logic [RCW-1:0]   rres;
  logic [RCW-1:0]   rfree;
  logic [4:0]       beat_cnt;
  logic [4:0]       beat_nxt;
  logic             burst_end;
  logic             err_q;
  logic             err_set;
  logic             cmd_push, cmd_pop, wd_push, wd_pop, rd_pop;
  logic             head_ok, fire_wr, fire_rd;
  logic [DATA_WIDTH+1:0] wd_dout;

  assign req_cmd.addr              = bus.req_addr & ~ADDR_WIDTH'(BURST_LEN - 1);
  assign req_cmd.rw                = bus.req_write ? WRITE_CMD : READ_CMD;
  assign req_cmd.auto_precharge_en = bus.req_ap;

  assign bus.req_ready   = (cmd_count != CCW'(CMD_DEPTH));
  assign bus.wr_ready    = (wd_count != WCW'(WDATA_DEPTH));
  assign bus.wdata_valid = (wd_count != '0);
  assign bus.rd_valid    = (rd_count != '0);
  assign bus.resp_ready  = 1'b1;
  assign bus.err_o       = err_q;

  assign cmd_push = bus.req_valid && bus.req_ready;
  assign cmd_pop  = bus.cmd_valid && bus.cmd_ready;
  assign wd_push  = bus.wr_valid && bus.wr_ready;
  assign wd_pop   = bus.wdata_valid && bus.wdata_ready;
  assign rd_pop   = bus.rd_valid && bus.rd_ready;

  sdram_cmd_frontend_fifo #(.WIDTH($bits(sdram_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rstn(rstn), .push(cmd_push), .pop(cmd_pop),
    .din(req_cmd), .dout(head), .count(cmd_count)
  );

  sdram_cmd_frontend_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(WDATA_DEPTH)) u_wd_fifo (
    .clk(clk), .rstn(rstn), .push(wd_push), .pop(wd_pop),
    .din({bus.wr_dqm, bus.wr_data}), .dout(wd_dout), .count(wd_count)
  );

  // Read beats are pushed unconditionally; reserved credit guarantees room
  sdram_cmd_frontend_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RDATA_DEPTH)) u_rd_fifo (
    .clk(clk), .rstn(rstn), .push(bus.resp_valid), .pop(rd_pop),
    .din(bus.resp_data), .dout(bus.rd_data), .count(rd_count)
  );

  assign bus.wdata     = wd_dout[DATA_WIDTH-1:0];
  assign bus.wdata_dqm = wd_dout[DATA_WIDTH+1:DATA_WIDTH];
  assign bus.cmd_data  = head;

  // Head release gated only by registered counts, never by cmd_ready
  assign wavail    = wd_count - wclaim;
  assign rfree     = RCW'(RDATA_DEPTH) - rd_count - rres;
  assign head_ok   = (head.rw == WRITE_CMD) ? (wavail >= WCW'(BURST_LEN))
                                            : (rfree  >= RCW'(BURST_LEN));
  assign bus.cmd_valid = (cmd_count != '0) && head_ok;
  assign fire_wr   = cmd_pop && (head.rw == WRITE_CMD);
  assign fire_rd   = cmd_pop && (head.rw == READ_CMD);

  assign beat_nxt  = beat_cnt + 5'd1;
  assign burst_end = (beat_nxt == 5'(BURST_LEN));
  assign err_set   = (bus.resp_valid && (bus.resp_last != burst_end))
                   || (bus.resp_valid && (rres == '0))
                   || (wd_pop && (wclaim == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wclaim   <= '0;
      rres     <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wclaim <= wclaim + (fire_wr ? WCW'(BURST_LEN) : WCW'(0)) - WCW'(wd_pop);
      rres   <= rres + (fire_rd ? RCW'(BURST_LEN) : RCW'(0)) - RCW'(bus.resp_valid);
      if (bus.resp_valid) begin
        beat_cnt <= (burst_end || bus.resp_last) ? 5'd0 : beat_nxt;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule
